// File: rtl/fifo_stream_reader_pkg.sv
// fifo_pkg: shared widths, output-queue depth and pointer helper for the FIFO stream reader
package fifo_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_CNT_W = 16;
  localparam int BUF_DEPTH = 3;
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return p == 2'd2 ? 2'd0 : p + 2'd1;
  endfunction
endpackage

// File: rtl/fifo_stream_reader_if.sv
// fifo_stream_reader_if: FIFO read port plus outgoing valid/ready stream
interface fifo_stream_reader_if
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) ();
  logic fifo_empty;
  logic fifo_rd_en;
  logic [DATA_W-1:0] fifo_rd_data;
  logic out_valid;
  logic out_ready;
  logic [DATA_W-1:0] out_data;
  modport master (
    input fifo_empty, fifo_rd_data, out_ready,
    output fifo_rd_en, out_valid, out_data
  );
  modport slave (
    output fifo_empty, fifo_rd_data, out_ready,
    input fifo_rd_en, out_valid, out_data
  );
endinterface

// File: rtl/fifo_stream_reader_skid_buf.sv
// stream_skid_buf: 3-entry register queue holding words returned by the FIFO
module stream_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic [1:0]        occ
);
  logic [DATA_W-1:0] mem [BUF_DEPTH];
  logic [1:0] hd, tl;
  assign head_data = mem[hd];
  // storage is cleared on reset so the head reads 0 out of reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hd <= '0;
      tl <= '0;
      occ <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[tl] <= push_data;
        tl <= ptr_inc(tl);
      end
      if (pop) hd <= ptr_inc(hd);
      occ <= occ + 2'(push) - 2'(pop);
    end
  end
endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a synchronous FIFO (1-cycle read latency) into a valid/ready stream
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  fifo_stream_reader_if.master bus,
  output logic                 busy,
  output logic [CNT_W-1:0]     words_out
);
  logic inflight, pop;
  logic [1:0] occ;
  // a read is only issued when a queue slot is reserved for its returning word
  assign bus.fifo_rd_en = rst_n & en & ~bus.fifo_empty & ({1'b0, occ} + {2'b0, inflight} < 3'(BUF_DEPTH));
  assign bus.out_valid = occ != 2'd0;
  assign pop = bus.out_valid & bus.out_ready;
  assign busy = bus.out_valid | inflight;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight <= 1'b0;
      words_out <= '0;
    end else begin
      inflight <= bus.fifo_rd_en;
      if (pop) words_out <= words_out + CNT_W'(1);
    end
  end
  stream_skid_buf #(.DATA_W(DATA_W)) u_buf (
    .clk(clk),
    .rst_n(rst_n),
    .push(inflight),
    .push_data(bus.fifo_rd_data),
    .pop(pop),
    .head_data(bus.out_data),
    .occ(occ)
  );
endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Drain-side companion to the team's synchronous FIFO. Issues rd_en against the FIFO's empty flag and absorbs its 1-cycle registered read latency.
- Re-presents the words as a valid/ready stream for downstream consumers, with full throughput, no loss and no duplication.
- Sits between the fifo read port (rd_en, rd_data, empty) and any stream sink. Keeps a running count of words delivered.

Parameters:
- DATA_W, 8, width of FIFO word and stream data.
- CNT_W, 16, width of delivered-word counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- en  input  1  drain enable; 0 stops new FIFO reads.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd_data  input  DATA_W  FIFO read data, valid the cycle after rd_en.
- fifo_rd_en  output  1  FIFO read strobe.
- out_valid  output  1  stream word available.
- out_ready  input  1  sink accepts word.
- out_data  output  DATA_W  stream word.
- busy  output  1  word in flight or buffered.
- words_out  output  CNT_W  count of accepted stream beats.

Behaviour:
- Reset is synchronous, active-low: the block samples rst_n==0 at a clk rise.
- Reset values:
  - occ=0, inflight=0, out_valid=0, out_data=0, busy=0, words_out=0.
  - fifo_rd_en is forced to 0 combinationally whenever rst_n==0.
- Internal state:
  - 3-entry output queue; occupancy occ ranges 0..3.
  - inflight flag: a read was issued last cycle.
- Issue rule:
  - fifo_rd_en = rst_n & en & ~fifo_empty & (occ + inflight < 3).
  - fifo_rd_en has no combinational dependence on out_ready.
- Capture:
  - When inflight=1, fifo_rd_data is written to the queue tail at that clk edge.
  - inflight_next = fifo_rd_en.
- Pop:
  - pop = out_valid & out_ready. Head is removed at the edge.
  - words_out increments by 1 per pop and wraps modulo 2^CNT_W.
- Outputs:
  - out_valid = (occ != 0). out_data = head entry, driven from registers.
  - out_data holds steady while out_valid & ~out_ready.
  - out_data is don't-care when out_valid=0.
- Occupancy update: occ_next = occ + inflight − pop. Capture and pop in the same cycle leave occ unchanged.
- Latency and throughput:
  - First word: rd_en at cycle N, out_valid at cycle N+2.
  - Steady state with out_ready=1: one word per cycle (occ=1, inflight=1 equilibrium).
- Boundaries:
  - Never overflow: the issue rule guarantees a free slot for every in-flight word.
  - Never read an empty FIFO.
  - out_ready low: the queue fills to 3, then rd_en stops.
  - en 0→1: a read can issue the same cycle.
  - en 1→0: no new reads. The in-flight word is still captured. Buffered words are still presented.
  - fifo_empty asserted while inflight: the capture still occurs.
- Reset mid-operation: the buffered and in-flight words are discarded (FIFO is reset alongside). words_out clears.
- busy = (occ != 0) | inflight.
- No state machine beyond occ/inflight. Head/tail pointers are 2-bit and wrap 2→0.

Decomposition:
- Package fifo_pkg:
  - DATA_W default 8, CNT_W default 16.
  - localparam BUF_DEPTH=3.
  - Function for the pointer increment-with-wrap (2→0).
- Sub-module stream_skid_buf:
  - 3-entry register queue with push, push_data, pop, head_data, occ.
  - Instantiated once. The issue/count logic stays in fifo_stream_reader.

Test Plan:
- Reset: rst_n=0 for 2 cycles with fifo_empty=0 and en=1 → fifo_rd_en=0, out_valid=0, words_out=0 throughout; first rd_en on the first cycle after release.
- Streaming: FIFO holds 0x11,0x22,0x33,0x44; en=1; out_ready=1 → out_data 0x11..0x44 on 4 consecutive cycles starting 2 cycles after the first rd_en; words_out=4; busy falls after the last beat.
- Backpressure: 5 words queued; out_ready=0 → exactly 3 rd_en pulses; occ=3; out_data=first word stable. Release ready → all 5 words in order, none lost or duplicated.
- Empty FIFO: fifo_empty=1, en=1 for 10 cycles → no rd_en, out_valid=0.
- Pause: en dropped in the same cycle as a rd_en → that word is still delivered; no further reads until en=1.
- Counter wrap and mid-operation reset: CNT_W=4, 17 words → words_out=1. Assert rst_n=0 with occ=2 → out_valid=0 and words_out=0 the next cycle.
